bw_edge_interp: RTL and testbench

- Sits directly downstream of the left-edge search stage.
- Takes the bracketing pair it reports: bins f1/f2 and normalized dB levels L1/L2, with L1 above and L2 at or below the -THRESHOLD_DB line.
- Computes a sub-bin, fixed-point frequency of the threshold crossing by linear interpolation.
- Uses a sequential restoring divider followed by a single-cycle multiply-accumulate.

---
 rtl/bw_edge_interp.sv | 154 +++++++++++++++
 tb/tb_bw_edge_interp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bw_edge_interp.sv
// Interpolates the sub-bin frequency where the spectrum crosses -THRESHOLD_DB between two bracketing bins.
// Restoring divider (FRAC_BITS+1 cycles) then one multiply-accumulate cycle; ready_o only in IDLE.
module bw_edge_interp #(
  parameter int ACCUM_WIDTH    = 16,
  parameter int FREQ_BIN_WIDTH = 9,
  parameter int THRESHOLD_DB   = 30,
  parameter int FRAC_BITS      = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                found_i,
  input  logic [FREQ_BIN_WIDTH-1:0]           f1_i,
  input  logic [FREQ_BIN_WIDTH-1:0]           f2_i,
  input  logic [ACCUM_WIDTH-1:0]              L1_i,
  input  logic [ACCUM_WIDTH-1:0]              L2_i,
  output logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0] f_edge_o,
  output logic                                edge_found_o,
  output logic                                err_o,
  output logic                                valid_o,
  output logic                                busy_o
);

  localparam int NW = ACCUM_WIDTH + 2;
  localparam int RW = NW + 1;
  localparam int DW = FREQ_BIN_WIDTH + 1;
  localparam int QW = FRAC_BITS + 1;
  localparam int OW = FREQ_BIN_WIDTH + FRAC_BITS;
  localparam int SW = OW + 2;
  localparam int CW = $clog2(FRAC_BITS + 1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [NW-1:0] THR      = NW'(THRESHOLD_DB);
  localparam logic        [CW-1:0] LAST_BIT = CW'(FRAC_BITS);

  logic [1:0]                r_state;
  logic [FREQ_BIN_WIDTH-1:0] r_f1;
  logic [FREQ_BIN_WIDTH-1:0] r_f2;
  logic [RW-1:0]             r_rem;
  logic [RW-1:0]             r_den;
  logic [QW-1:0]             r_q;
  logic [CW-1:0]             r_cnt;
  logic [OW-1:0]             r_f_edge;
  logic                      r_edge_found;
  logic                      r_err;

  logic signed [NW-1:0] w_l1;
  logic signed [NW-1:0] w_l2;
  logic signed [NW-1:0] w_num;
  logic signed [NW-1:0] w_den;
  logic                 w_consistent;
  logic                 w_accept;
  logic                 w_ge;
  logic [RW-1:0]        w_sub;
  logic signed [DW-1:0] w_delta;
  logic signed [SW-1:0] w_qx;
  logic signed [SW-1:0] w_dx;
  logic signed [SW-1:0] w_base;
  logic signed [SW-1:0] w_sum;
  logic [OW-1:0]        w_clamped;

  assign w_l1  = {{2{L1_i[ACCUM_WIDTH-1]}}, L1_i};
  assign w_l2  = {{2{L2_i[ACCUM_WIDTH-1]}}, L2_i};
  assign w_num = w_l1 + THR;
  assign w_den = w_l1 - w_l2;

  // num>0, den>0 and num<=den guarantees the quotient stays within 0..2^FRAC_BITS
  assign w_consistent = !w_num[NW-1] && (w_num != '0) &&
                        !w_den[NW-1] && (w_den != '0) && (w_num <= w_den);
  assign w_accept     = valid_i && (r_state == S_IDLE);

  assign w_ge  = (r_rem >= r_den);
  assign w_sub = w_ge ? (r_rem - r_den) : r_rem;

  assign w_delta = $signed({1'b0, r_f2}) - $signed({1'b0, r_f1});
  assign w_qx    = {{(SW-QW){1'b0}}, r_q};
  assign w_dx    = {{(SW-DW){w_delta[DW-1]}}, w_delta};
  assign w_base  = {2'b00, r_f1, {FRAC_BITS{1'b0}}};
  assign w_sum   = w_base + w_qx * w_dx;

  always_comb begin
    w_clamped = w_sum[OW-1:0];
    if (w_sum[SW-1])      w_clamped = '0;
    else if (w_sum[SW-2]) w_clamped = '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_f1         <= '0;
      r_f2         <= '0;
      r_rem        <= '0;
      r_den        <= '0;
      r_q          <= '0;
      r_cnt        <= '0;
      r_f_edge     <= '0;
      r_edge_found <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f1  <= f1_i;
            r_f2  <= f2_i;
            r_rem <= {1'b0, w_num};
            r_den <= {1'b0, w_den};
            r_q   <= '0;
            r_cnt <= '0;
            if (!found_i) begin
              r_f_edge     <= '0;
              r_edge_found <= 1'b0;
              r_err        <= 1'b0;
              r_state      <= S_DONE;
            end else if (!w_consistent) begin
              r_f_edge     <= {f1_i, {FRAC_BITS{1'b0}}};
              r_edge_found <= 1'b1;
              r_err        <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          // remainder is always below den here, so the shift cannot overflow
          r_rem <= {w_sub[RW-2:0], 1'b0};
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) r_state <= S_MUL;
        end
        S_MUL: begin
          r_f_edge     <= w_clamped;
          r_edge_found <= 1'b1;
          r_err        <= 1'b0;
          r_state      <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = (r_state == S_IDLE);
  assign busy_o       = (r_state == S_DIV) || (r_state == S_MUL);
  assign valid_o      = (r_state == S_DONE);
  assign f_edge_o     = r_f_edge;
  assign edge_found_o = r_edge_found;
  assign err_o        = r_err;

endmodule

// File: tb/tb_bw_edge_interp.sv
// Directed and randomized checks of bw_edge_interp against an integer-arithmetic reference model.
module tb_bw_edge_interp;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        found_i;
  logic [8:0]  f1_i;
  logic [8:0]  f2_i;
  logic [15:0] L1_i;
  logic [15:0] L2_i;
  logic [12:0] f_edge_o;
  logic        edge_found_o;
  logic        err_o;
  logic        valid_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  bw_edge_interp dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .found_i(found_i), .f1_i(f1_i), .f2_i(f2_i), .L1_i(L1_i), .L2_i(L2_i),
    .f_edge_o(f_edge_o), .edge_found_o(edge_found_o), .err_o(err_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: crossing = f1 + floor(16*num/den)/16 * (f2-f1), in 1/16 bin units
  task automatic model(input bit found, input int f1, input int f2, input int l1, input int l2,
                       output int fe, output bit ef, output bit er, output int lat, output int nbusy);
    int num, den, q, s;
    num = l1 + 30;
    den = l1 - l2;
    lat = 1; nbusy = 0;
    if (!found) begin
      fe = 0; ef = 0; er = 0;
    end else if (!(num > 0 && den > 0 && num <= den)) begin
      fe = f1 * 16; ef = 1; er = 1;
    end else begin
      q  = (num * 16) / den;
      s  = f1 * 16 + q * (f2 - f1);
      fe = (s < 0) ? 0 : (s > 8191) ? 8191 : s;
      ef = 1; er = 0;
      lat = 7; nbusy = 6;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_fedge"}, f_edge_o, 0);
    check({tag, "_found"}, edge_found_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic run_txn(input string tag, input bit found, input int f1, input int f2,
                         input int l1, input int l2, input bit inject);
    int  fe, lat_exp, busy_exp, lat, nbusy;
    bit  ef, er, seen;
    model(found, f1, f2, l1, l2, fe, ef, er, lat_exp, busy_exp);
    @(posedge clk_i); #1;
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_valid_low"}, valid_o, 0);
    valid_i = 1'b1; found_i = found;
    f1_i = 9'(f1); f2_i = 9'(f2); L1_i = 16'(l1); L2_i = 16'(l2);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1; nbusy = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (valid_o) begin
        seen = 1;
      end else begin
        if (busy_o) nbusy++;
        if (inject && lat == 2) begin
          check({tag, "_ready_busy"}, ready_o, 0);
          valid_i = 1'b1; found_i = 1'b1;
          f1_i = 9'd3; f2_i = 9'd4; L1_i = 16'hFFF6; L2_i = 16'hFFE2;
        end else begin
          valid_i = 1'b0;
        end
        @(posedge clk_i); #1;
        lat++;
      end
    end
    valid_i = 1'b0;
    check({tag, "_timeout"}, seen, 1);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_busy_cycles"}, nbusy, busy_exp);
    check({tag, "_fedge"}, f_edge_o, fe);
    check({tag, "_found"}, edge_found_o, ef);
    check({tag, "_err"}, err_o, er);
  endtask

  initial begin
    int f1, f2, l1, l2;
    logic signed [15:0] t1, t2;
    rst_ni = 1'b0; valid_i = 1'b0; found_i = 1'b0;
    f1_i = '0; f2_i = '0; L1_i = '0; L2_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    run_txn("normal",      1, 100, 101, -20, -40, 0);
    run_txn("exact_thr",   1, 100, 101, -10, -30, 0);
    run_txn("descending",  1, 101, 100, -25, -35, 0);
    run_txn("low_bin",     1,   0,   1, -29, -31, 0);
    run_txn("wide_span",   1,   0, 511, -10, -30, 0);
    run_txn("equal_bins",  1,  77,  77, -20, -40, 0);
    run_txn("not_found",   0,  55,  56, -20, -40, 0);
    run_txn("err_order",   1,  42,  43, -40, -20, 0);
    run_txn("err_flat",    1,  42,  43, -20, -20, 0);
    run_txn("inject",      1, 200, 201, -20, -40, 1);
    run_txn("back2back",   1, 300, 299, -28, -32, 0);

    // Reset asserted in the third DIV cycle: outputs must drop at once, no valid pulse
    @(posedge clk_i); #1;
    valid_i = 1'b1; found_i = 1'b1; f1_i = 9'd10; f2_i = 9'd11; L1_i = 16'hFFEC; L2_i = 16'hFFD8;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("middiv_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("middiv");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      check("middiv_novalid", valid_o, 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_txn("after_reset", 1, 10, 11, -20, -40, 0);

    for (int i = 0; i < 40; i++) begin
      f1 = int'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) f2 = int'($urandom_range(0, 511));
      else if (f1 == 511 || (f1 > 0 && $urandom_range(0, 1) == 1)) f2 = f1 - 1;
      else f2 = f1 + 1;
      if ($urandom_range(0, 4) == 0) begin
        t1 = 16'($urandom); t2 = 16'($urandom);
        l1 = int'(t1); l2 = int'(t2);
      end else begin
        l1 = int'($urandom_range(0, 60)) - 50;
        l2 = l1 - int'($urandom_range(0, 40));
      end
      run_txn("random", ($urandom_range(0, 7) != 0), f1, f2, l1, l2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
